nib_ram_arbiter: RTL

Two-master arbiter placed in front of the shared data RAM slave port. It lets core0 and core1 EX-stage load/store ports share one single-port synchronous RAM. Grants are round-robin with an optional per-master lock for atomic read-modify-write sequences. Losing masters are stalled through `hold_o`, and each read return is steered to the master that issued it.

---
 rtl/nib_ram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nib_ram_arbiter.sv
// ----------------------------------------------------------------------------
// nib_ram_arbiter
//   Two-master round-robin arbiter in front of the shared single-port data RAM.
//   Optional per-master lock keeps ownership for atomic read-modify-write
//   sequences. Losing masters are stalled through m_hold_o, and each read
//   return is steered to the master that issued it.
//
//   Optional feature macro: NIB_ARB_LOCK_TIMEOUT_EN
//     When defined, a lock is forcibly released after LOCK_MAX consecutive
//     grants if the other master is waiting.
//
// Ports
//   clk, rstn        : clock, synchronous active-low reset
//   m_data_req_i     : per-master access request
//   m_lock_i         : per-master lock (keep ownership next cycle)
//   m_addr_i         : per-master address
//   m_wr_en_i        : per-master write enable (0 = read)
//   m_wr_data_i      : per-master write data
//   m_rd_data_o      : per-master read data (live on valid, else last value)
//   m_rd_valid_o     : per-master read data valid
//   m_hold_o         : per-master stall (request not granted this cycle)
//   s_data_req_o     : RAM access strobe
//   s_addr_o         : RAM address
//   s_wr_en_o        : RAM write enable
//   s_wr_data_o      : RAM write data
//   s_rd_data_i      : RAM read data, one cycle after a read strobe
// ----------------------------------------------------------------------------
module nib_ram_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          m_data_req_i,
    input  logic [1:0]          m_lock_i,
    input  logic [1:0][AW-1:0]  m_addr_i,
    input  logic [1:0]          m_wr_en_i,
    input  logic [1:0][DW-1:0]  m_wr_data_i,
    output logic [1:0][DW-1:0]  m_rd_data_o,
    output logic [1:0]          m_rd_valid_o,
    output logic [1:0]          m_hold_o,
    output logic                s_data_req_o,
    output logic [AW-1:0]       s_addr_o,
    output logic                s_wr_en_o,
    output logic [DW-1:0]       s_wr_data_o,
    input  logic [DW-1:0]       s_rd_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_owner_q, rd_owner_d;
    logic [1:0][DW-1:0] rd_keep_q, rd_keep_d;

    logic [1:0]         gnt;
    logic               brk;
    logic               rd_live;

`ifdef NIB_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_MAX) + 1;

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    // Break only while the owner still wants the RAM and the other master waits.
    always_comb begin
        brk = 1'b0;
        if (lock_cnt_q == CW'(LOCK_MAX - 1)) begin
            if (state_q == OWN0 && m_data_req_i[0] && m_data_req_i[1]) brk = 1'b1;
            if (state_q == OWN1 && m_data_req_i[1] && m_data_req_i[0]) brk = 1'b1;
        end
    end

    // Counts grants made while owned; saturates at the threshold so a lone
    // owner keeps the break armed until the other master shows up.
    always_comb begin
        lock_cnt_d = '0;
        if (!brk && ((state_q == OWN0 && gnt[0]) || (state_q == OWN1 && gnt[1]))) begin
            if (lock_cnt_q == CW'(LOCK_MAX - 1)) lock_cnt_d = lock_cnt_q;
            else                                 lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) lock_cnt_q <= '0;
        else       lock_cnt_q <= lock_cnt_d;
    end
`else
    always_comb brk = 1'b0;
`endif

    // Grant, next state and round-robin pointer.
    always_comb begin
        gnt     = '0;
        state_d = IDLE;
        last_d  = last_q;
        if (!rstn) begin
            gnt = '0;
        end else if (brk) begin
            gnt = (state_q == OWN0) ? 2'b10 : 2'b01;
        end else if (state_q == OWN0 && m_data_req_i[0]) begin
            gnt = 2'b01;
        end else if (state_q == OWN1 && m_data_req_i[1]) begin
            gnt = 2'b10;
        end else if (&m_data_req_i) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else if (m_data_req_i[0]) begin
            gnt = 2'b01;
        end else if (m_data_req_i[1]) begin
            gnt = 2'b10;
        end

        if (gnt[0]) begin
            last_d = 1'b0;
            if (m_lock_i[0] && !brk) state_d = OWN0;
        end
        if (gnt[1]) begin
            last_d = 1'b1;
            if (m_lock_i[1] && !brk) state_d = OWN1;
        end
    end

    // Slave port mux and stall outputs.
    always_comb begin
        s_data_req_o = |gnt;
        s_addr_o     = '0;
        s_wr_en_o    = 1'b0;
        s_wr_data_o  = '0;
        if (gnt[0]) begin
            s_addr_o    = m_addr_i[0];
            s_wr_en_o   = m_wr_en_i[0];
            s_wr_data_o = m_wr_data_i[0];
        end else if (gnt[1]) begin
            s_addr_o    = m_addr_i[1];
            s_wr_en_o   = m_wr_en_i[1];
            s_wr_data_o = m_wr_data_i[1];
        end
        m_hold_o = m_data_req_i & ~gnt;
    end

    // Read return steering; reset suppresses an in-flight return immediately.
    always_comb begin
        rd_live      = rd_pend_q & rstn;
        m_rd_valid_o = '0;
        rd_keep_d    = rd_keep_q;
        m_rd_data_o  = rd_keep_q;
        if (rd_live) begin
            m_rd_valid_o[rd_owner_q] = 1'b1;
            m_rd_data_o[rd_owner_q]  = s_rd_data_i;
            rd_keep_d[rd_owner_q]    = s_rd_data_i;
        end

        rd_pend_d  = (|gnt) & ~s_wr_en_o;
        rd_owner_d = (|gnt) ? gnt[1] : rd_owner_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_keep_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_keep_q  <= rd_keep_d;
        end
    end

endmodule
